// File: rtl/sha256_ctrl_if.sv
// Control bus between the SHA-256 sequencer and its host, message memory and datapath.
// When SHA_CTRL_CYCLE_CNT_EN is defined the bus also carries the busy-cycle counter.
interface sha256_ctrl_if #(
  parameter int BLK_W = 4
);
  logic             start;
  logic             restart;
  logic [BLK_W-1:0] num_blocks;
  logic             msg_rd_en;
  logic [BLK_W+3:0] msg_addr;
  logic             w_load_en;
  logic [3:0]       w_idx;
  logic             init_hash;
  logic             round_en;
  logic [5:0]       round_idx;
  logic             hash_update;
  logic             dig_wr_en;
  logic [2:0]       dig_addr;
  logic             busy;
  logic             done;
`ifdef SHA_CTRL_CYCLE_CNT_EN
  logic [31:0]      cycle_cnt;
`endif

  modport master (
    input  start, restart, num_blocks,
    output msg_rd_en, msg_addr, w_load_en, w_idx, init_hash, round_en, round_idx,
           hash_update, dig_wr_en, dig_addr, busy, done
`ifdef SHA_CTRL_CYCLE_CNT_EN
    , output cycle_cnt
`endif
  );

  modport slave (
    output start, restart, num_blocks,
    input  msg_rd_en, msg_addr, w_load_en, w_idx, init_hash, round_en, round_idx,
           hash_update, dig_wr_en, dig_addr, busy, done
`ifdef SHA_CTRL_CYCLE_CNT_EN
    , input cycle_cnt
`endif
  );
endinterface

// File: rtl/sha256_ctrl.sv
// SHA-256 top-level sequencer: message fetch, 64 rounds, hash fold per block, digest write-out.
// Optional busy-cycle counter enabled by defining SHA_CTRL_CYCLE_CNT_EN.
module sha256_ctrl #(
  parameter int BLK_W = 4
) (
  input logic           clock,
  input logic           reset,
  sha256_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    ROUND  = 3'd3,
    UPDATE = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [BLK_W-1:0] BLK_ONE = {{(BLK_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] last_q, last_d;

  logic             msg_rd_en_q, msg_rd_en_d;
  logic [BLK_W+3:0] msg_addr_q, msg_addr_d;
  logic             w_load_en_q, w_load_en_d;
  logic [3:0]       w_idx_q, w_idx_d;
  logic             init_hash_q, init_hash_d;
  logic             round_en_q, round_en_d;
  logic [5:0]       round_idx_q, round_idx_d;
  logic             hash_update_q, hash_update_d;
  logic             dig_wr_en_q, dig_wr_en_d;
  logic [2:0]       dig_addr_q, dig_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Outputs are computed for the state being entered so every strobe lines up
  // with its state cycle while still coming straight from a flop.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    blk_d         = blk_q;
    last_d        = last_q;
    msg_rd_en_d   = 1'b0;
    msg_addr_d    = '0;
    w_load_en_d   = 1'b0;
    w_idx_d       = 4'd0;
    init_hash_d   = 1'b0;
    round_en_d    = 1'b0;
    round_idx_d   = 6'd0;
    hash_update_d = 1'b0;
    dig_wr_en_d   = 1'b0;
    dig_addr_d    = 3'd0;

    if (bus.restart) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
      blk_d   = '0;
      last_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d     = LOAD;
            cnt_d       = 6'd0;
            blk_d       = '0;
            last_d      = (bus.num_blocks == '0) ? '0 : bus.num_blocks - BLK_ONE;
            msg_rd_en_d = 1'b1;
            msg_addr_d  = '0;
            init_hash_d = 1'b1;
          end
        end

        LOAD: begin
          // One-cycle memory latency: the word requested now lands next cycle.
          w_load_en_d = 1'b1;
          w_idx_d     = cnt_q[3:0];
          if (cnt_q == 6'd15) begin
            state_d = DRAIN;
            cnt_d   = 6'd0;
          end else begin
            cnt_d       = cnt_q + 6'd1;
            msg_rd_en_d = 1'b1;
            msg_addr_d  = {blk_q, cnt_d[3:0]};
          end
        end

        DRAIN: begin
          state_d     = ROUND;
          cnt_d       = 6'd0;
          round_en_d  = 1'b1;
          round_idx_d = 6'd0;
        end

        ROUND: begin
          if (cnt_q == 6'd63) begin
            state_d       = UPDATE;
            cnt_d         = 6'd0;
            hash_update_d = 1'b1;
          end else begin
            cnt_d       = cnt_q + 6'd1;
            round_en_d  = 1'b1;
            round_idx_d = cnt_d;
          end
        end

        UPDATE: begin
          if (blk_q < last_q) begin
            state_d     = LOAD;
            cnt_d       = 6'd0;
            blk_d       = blk_q + BLK_ONE;
            msg_rd_en_d = 1'b1;
            msg_addr_d  = {blk_d, 4'd0};
          end else begin
            state_d     = WRITE;
            cnt_d       = 6'd0;
            dig_wr_en_d = 1'b1;
            dig_addr_d  = 3'd0;
          end
        end

        WRITE: begin
          if (cnt_q == 6'd7) begin
            state_d = DONE;
            cnt_d   = 6'd0;
          end else begin
            cnt_d       = cnt_q + 6'd1;
            dig_wr_en_d = 1'b1;
            dig_addr_d  = cnt_d[2:0];
          end
        end

        DONE: begin
          state_d = DONE;
        end

        default: begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // State, counters and output flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 6'd0;
      blk_q         <= '0;
      last_q        <= '0;
      msg_rd_en_q   <= 1'b0;
      msg_addr_q    <= '0;
      w_load_en_q   <= 1'b0;
      w_idx_q       <= 4'd0;
      init_hash_q   <= 1'b0;
      round_en_q    <= 1'b0;
      round_idx_q   <= 6'd0;
      hash_update_q <= 1'b0;
      dig_wr_en_q   <= 1'b0;
      dig_addr_q    <= 3'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      blk_q         <= blk_d;
      last_q        <= last_d;
      msg_rd_en_q   <= msg_rd_en_d;
      msg_addr_q    <= msg_addr_d;
      w_load_en_q   <= w_load_en_d;
      w_idx_q       <= w_idx_d;
      init_hash_q   <= init_hash_d;
      round_en_q    <= round_en_d;
      round_idx_q   <= round_idx_d;
      hash_update_q <= hash_update_d;
      dig_wr_en_q   <= dig_wr_en_d;
      dig_addr_q    <= dig_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.msg_rd_en   = msg_rd_en_q;
  assign bus.msg_addr    = msg_addr_q;
  assign bus.w_load_en   = w_load_en_q;
  assign bus.w_idx       = w_idx_q;
  assign bus.init_hash   = init_hash_q;
  assign bus.round_en    = round_en_q;
  assign bus.round_idx   = round_idx_q;
  assign bus.hash_update = hash_update_q;
  assign bus.dig_wr_en   = dig_wr_en_q;
  assign bus.dig_addr    = dig_addr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

`ifdef SHA_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic        launch;

  assign launch = (state_q == IDLE) && bus.start && !bus.restart;

  // Counts cycles spent busy; cleared on every launch, saturates rather than wraps.
  always_ff @(posedge clock) begin
    if (reset || bus.restart || launch) begin
      cycle_cnt_q <= 32'd0;
    end else if (busy_q && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_ctrl.sv
// Directed self-checking bench for sha256_ctrl; cycle k counts edges after the one sampling start.
// Define SHA_CTRL_CYCLE_CNT_EN to also exercise the busy-cycle counter.
module tb_sha256_ctrl;
  localparam int BLK_W = 4;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  sha256_ctrl_if #(.BLK_W(BLK_W)) bus();

  sha256_ctrl #(.BLK_W(BLK_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Index fields are masked by their strobes; only the strobe-qualified value is meaningful.
  function automatic logic [28:0] obs_vec();
    return {bus.msg_rd_en, bus.msg_addr & {8{bus.msg_rd_en}},
            bus.w_load_en, bus.w_idx & {4{bus.w_load_en}},
            bus.init_hash, bus.round_en, bus.round_idx & {6{bus.round_en}},
            bus.hash_update, bus.dig_wr_en, bus.dig_addr & {3{bus.dig_wr_en}},
            bus.busy, bus.done};
  endfunction

  // Expected outputs in cycle k of a hash of nb blocks, from the published timing table.
  function automatic logic [28:0] exp_vec(input int k, input int nb);
    logic       rd, wl, ih, re, hu, dw, bz, dn;
    logic [7:0] addr;
    logic [3:0] wi;
    logic [5:0] ri;
    logic [2:0] da;
    int n, b, o;
    n = (nb == 0) ? 1 : nb;
    {rd, wl, ih, re, hu, dw, bz, dn} = '0;
    addr = '0; wi = '0; ri = '0; da = '0;
    if (k >= 1 && k <= 82 * n) begin
      b  = (k - 1) / 82;
      o  = k - 82 * b;
      bz = 1'b1;
      if (o <= 16) begin rd = 1'b1; addr = 8'(b * 16 + o - 1); ih = (b == 0 && o == 1); end
      if (o >= 2 && o <= 17) begin wl = 1'b1; wi = 4'(o - 2); end
      if (o >= 18 && o <= 81) begin re = 1'b1; ri = 6'(o - 18); end
      if (o == 82) hu = 1'b1;
    end else if (k > 82 * n && k <= 82 * n + 8) begin
      bz = 1'b1; dw = 1'b1; da = 3'(k - 82 * n - 1);
    end else if (k > 82 * n + 8) begin
      dn = 1'b1;
    end
    return {rd, addr, wl, wi, ih, re, ri, hu, dw, da, bz, dn};
  endfunction

  task automatic launch(input logic [3:0] nb, input bit hold);
    @(negedge clock);
    bus.num_blocks = nb;
    bus.start      = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic rearm();
    @(negedge clock);
    bus.restart = 1'b1;
    @(posedge clock);
    #1;
    bus.restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.restart = 1'b0; bus.num_blocks = 4'd1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (obs_vec() !== 29'd0) begin
      n_fail++; $display("[TB] FAIL reset_state: got %h expected %h", obs_vec(), 29'd0);
    end
`ifdef SHA_CTRL_CYCLE_CNT_EN
    n_checks++;
    if (bus.cycle_cnt !== 32'd0) begin
      n_fail++; $display("[TB] FAIL reset_cycle_cnt: got %0d expected 0", bus.cycle_cnt);
    end
`endif
    reset = 1'b0; bus.start = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs_vec() !== 29'd0) begin
      n_fail++; $display("[TB] FAIL idle_after_reset: got %h expected %h", obs_vec(), 29'd0);
    end
  endtask

  task automatic test_single_block();
    launch(4'd1, 1'b0);
    for (int k = 1; k <= 95; k++) begin
      @(negedge clock);
      n_checks++;
      if (obs_vec() !== exp_vec(k, 1)) begin
        n_fail++; $display("[TB] FAIL single_block cycle %0d: got %h expected %h", k, obs_vec(), exp_vec(k, 1));
      end
    end
    rearm();
  endtask

  task automatic test_multi_block();
    int ih_cnt = 0;
    int hu_cnt = 0;
    launch(4'd3, 1'b0);
    for (int k = 1; k <= 260; k++) begin
      @(negedge clock);
      if (bus.init_hash) ih_cnt++;
      if (bus.hash_update) hu_cnt++;
      n_checks++;
      if (obs_vec() !== exp_vec(k, 3)) begin
        n_fail++; $display("[TB] FAIL multi_block cycle %0d: got %h expected %h", k, obs_vec(), exp_vec(k, 3));
      end
    end
    n_checks++;
    if (ih_cnt !== 1) begin
      n_fail++; $display("[TB] FAIL init_hash_count: got %0d expected 1", ih_cnt);
    end
    n_checks++;
    if (hu_cnt !== 3) begin
      n_fail++; $display("[TB] FAIL hash_update_count: got %0d expected 3", hu_cnt);
    end
    rearm();
  endtask

  task automatic test_zero_blocks();
    launch(4'd0, 1'b0);
    bus.num_blocks = 4'd9;
    for (int k = 1; k <= 95; k++) begin
      @(negedge clock);
      n_checks++;
      if (obs_vec() !== exp_vec(k, 1)) begin
        n_fail++; $display("[TB] FAIL zero_blocks cycle %0d: got %h expected %h", k, obs_vec(), exp_vec(k, 1));
      end
    end
    rearm();
  endtask

  task automatic test_restart_in_round();
    launch(4'd2, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      @(negedge clock);
      n_checks++;
      if (obs_vec() !== exp_vec(k, 2)) begin
        n_fail++; $display("[TB] FAIL pre_restart cycle %0d: got %h expected %h", k, obs_vec(), exp_vec(k, 2));
      end
    end
    bus.restart = 1'b1;
    @(posedge clock);
    #1;
    bus.restart = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs_vec() !== 29'd0) begin
      n_fail++; $display("[TB] FAIL restart_idle: got %h expected %h", obs_vec(), 29'd0);
    end
    launch(4'd1, 1'b0);
    @(negedge clock);
    n_checks++;
    if (obs_vec() !== exp_vec(1, 1)) begin
      n_fail++; $display("[TB] FAIL relaunch: got %h expected %h", obs_vec(), exp_vec(1, 1));
    end
    rearm();
  endtask

  task automatic test_start_held_in_done();
    launch(4'd1, 1'b1);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      n_checks++;
      if (obs_vec() !== exp_vec(k, 1)) begin
        n_fail++; $display("[TB] FAIL start_held cycle %0d: got %h expected %h", k, obs_vec(), exp_vec(k, 1));
      end
    end
    bus.restart = 1'b1;
    @(posedge clock);
    #1;
    bus.restart = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs_vec() !== 29'd0) begin
      n_fail++; $display("[TB] FAIL restart_beats_start: got %h expected %h", obs_vec(), 29'd0);
    end
    @(negedge clock);
    n_checks++;
    if (obs_vec() !== exp_vec(1, 1)) begin
      n_fail++; $display("[TB] FAIL launch_after_restart: got %h expected %h", obs_vec(), exp_vec(1, 1));
    end
    bus.start = 1'b0;
    rearm();
    @(negedge clock);
    n_checks++;
    if (obs_vec() !== 29'd0) begin
      n_fail++; $display("[TB] FAIL final_idle: got %h expected %h", obs_vec(), 29'd0);
    end
  endtask

`ifdef SHA_CTRL_CYCLE_CNT_EN
  task automatic test_cycle_cnt();
    launch(4'd1, 1'b0);
    for (int k = 1; k <= 95; k++) begin
      @(negedge clock);
      if (k == 1 || k == 50 || k == 91 || k == 95) begin
        n_checks++;
        if (bus.cycle_cnt !== 32'((k > 91) ? 90 : k - 1)) begin
          n_fail++; $display("[TB] FAIL cycle_cnt cycle %0d: got %0d expected %0d", k, bus.cycle_cnt, (k > 91) ? 90 : k - 1);
        end
      end
    end
    rearm();
    @(negedge clock);
    n_checks++;
    if (bus.cycle_cnt !== 32'd0) begin
      n_fail++; $display("[TB] FAIL cycle_cnt_restart: got %0d expected 0", bus.cycle_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_block();
    test_multi_block();
    test_zero_blocks();
    test_restart_in_round();
    test_start_held_in_done();
`ifdef SHA_CTRL_CYCLE_CNT_EN
    test_cycle_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
